// File: rtl/reg_file_mp.sv
// Multi-port register file with write-back scoreboard; reads registered (1-cycle latency), x0 hardwired to zero.
// REG_FILE_BYPASS_EN: same-edge read/write collisions return the post-write data and busy state instead of the old values.
module reg_file_mp #(
  parameter int NUM_REG        = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int REG_WIDTH      = 32,
  parameter int NUM_RD_PORTS   = 2,
  parameter int CNT_WIDTH      = 6
) (
  input  logic                                   clk,
  input  logic                                   reset_n,
  input  logic [NUM_RD_PORTS-1:0]                rd_en,
  input  logic [NUM_RD_PORTS*REG_ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_RD_PORTS*REG_WIDTH-1:0]      rd_data,
  output logic [NUM_RD_PORTS-1:0]                rd_busy,
  input  logic                                   wr_en,
  input  logic [REG_ADDR_WIDTH-1:0]              wr_addr,
  input  logic [REG_WIDTH-1:0]                   wr_data,
  input  logic                                   iss_en,
  input  logic [REG_ADDR_WIDTH-1:0]              iss_addr,
  output logic [CNT_WIDTH-1:0]                   busy_cnt
);

  // x0 has no storage; out-of-range addresses never match a decode slot
  logic [REG_WIDTH-1:0] regs [1:NUM_REG-1];
  logic [NUM_REG-1:1]   busy;
  logic [NUM_REG-1:1]   busy_nxt;

  logic wr_hit;
  logic iss_hit;
  logic wr_was_busy;
  logic iss_was_busy;
  logic cnt_inc;
  logic cnt_dec;

  logic [NUM_RD_PORTS*REG_WIDTH-1:0] rd_data_nxt;
  logic [NUM_RD_PORTS-1:0]           rd_busy_nxt;

  always_comb begin
    wr_hit       = 1'b0;
    iss_hit      = 1'b0;
    wr_was_busy  = 1'b0;
    iss_was_busy = 1'b0;
    busy_nxt     = busy;
    for (int r = 1; r < NUM_REG; r++) begin
      if (wr_en && wr_addr == REG_ADDR_WIDTH'(r)) begin
        wr_hit      = 1'b1;
        wr_was_busy = busy[r];
        busy_nxt[r] = 1'b0;
      end
    end
    // issue is applied after write-back so the newer producer keeps the bit set
    for (int r = 1; r < NUM_REG; r++) begin
      if (iss_en && iss_addr == REG_ADDR_WIDTH'(r)) begin
        iss_hit      = 1'b1;
        iss_was_busy = busy[r];
        busy_nxt[r]  = 1'b1;
      end
    end
    cnt_inc = iss_hit && !iss_was_busy;
    cnt_dec = wr_hit && wr_was_busy && !(iss_hit && iss_addr == wr_addr);
  end

  always_comb begin
    rd_data_nxt = '0;
    rd_busy_nxt = '0;
    for (int p = 0; p < NUM_RD_PORTS; p++) begin
      for (int r = 1; r < NUM_REG; r++) begin
        if (rd_addr[p*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] == REG_ADDR_WIDTH'(r)) begin
`ifdef REG_FILE_BYPASS_EN
          if (wr_en && wr_addr == REG_ADDR_WIDTH'(r))
            rd_data_nxt[p*REG_WIDTH +: REG_WIDTH] = wr_data;
          else
            rd_data_nxt[p*REG_WIDTH +: REG_WIDTH] = regs[r];
          rd_busy_nxt[p] = busy_nxt[r];
`else
          rd_data_nxt[p*REG_WIDTH +: REG_WIDTH] = regs[r];
          rd_busy_nxt[p] = busy[r];
`endif
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 1; r < NUM_REG; r++) regs[r] <= '0;
      busy     <= '0;
      busy_cnt <= '0;
      rd_data  <= '0;
      rd_busy  <= '0;
    end else begin
      for (int r = 1; r < NUM_REG; r++) begin
        if (wr_en && wr_addr == REG_ADDR_WIDTH'(r)) regs[r] <= wr_data;
      end
      busy <= busy_nxt;
      if (cnt_inc && !cnt_dec)
        busy_cnt <= busy_cnt + CNT_WIDTH'(1);
      else if (cnt_dec && !cnt_inc)
        busy_cnt <= busy_cnt - CNT_WIDTH'(1);
      for (int p = 0; p < NUM_RD_PORTS; p++) begin
        if (rd_en[p]) begin
          rd_data[p*REG_WIDTH +: REG_WIDTH] <= rd_data_nxt[p*REG_WIDTH +: REG_WIDTH];
          rd_busy[p]                        <= rd_busy_nxt[p];
        end
      end
    end
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Randomized and directed bench for reg_file_mp (NUM_REG=24, 2 read ports) against an array-based reference model.
module tb_reg_file_mp;

  localparam int NR = 24;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NP = 2;
  localparam int CW = 6;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic [NP-1:0] rd_en = '0;
  logic [NP*AW-1:0] rd_addr = '0;
  logic [NP*DW-1:0] rd_data;
  logic [NP-1:0] rd_busy;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          iss_en = 1'b0;
  logic [AW-1:0] iss_addr = '0;
  logic [CW-1:0] busy_cnt;

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] m_regs [32];
  bit            m_busy [32];
  logic [DW-1:0] e_rd [NP];
  bit            e_rb [NP];

  reg_file_mp #(.NUM_REG(NR), .REG_ADDR_WIDTH(AW), .REG_WIDTH(DW),
                .NUM_RD_PORTS(NP), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset_n(reset_n), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_busy(rd_busy), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .iss_en(iss_en), .iss_addr(iss_addr), .busy_cnt(busy_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int model_cnt();
    int c = 0;
    for (int i = 0; i < 32; i++) c += int'(m_busy[i]);
    return c;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
    for (int p = 0; p < NP; p++) begin
      e_rd[p] = '0;
      e_rb[p] = 1'b0;
    end
  endfunction

  task automatic check_outputs(input string tag);
    for (int p = 0; p < NP; p++) begin
      chk($sformatf("%s rd_data%0d", tag, p), 64'(rd_data[p*DW +: DW]), 64'(e_rd[p]));
      chk($sformatf("%s rd_busy%0d", tag, p), 64'(rd_busy[p]), 64'(e_rb[p]));
    end
    chk({tag, " busy_cnt"}, 64'(busy_cnt), 64'(model_cnt()));
  endtask

  // one clock: drive inputs, predict with the model, sample 1 time unit after the edge
  task automatic step(input string tag, input logic [NP-1:0] re, input logic [AW-1:0] ra0,
                      input logic [AW-1:0] ra1, input logic we, input logic [AW-1:0] wa,
                      input logic [DW-1:0] wd, input logic ie, input logic [AW-1:0] ia);
    logic [DW-1:0] n_regs [32];
    bit            n_busy [32];
    int            a;
    rd_en = re; rd_addr = {ra1, ra0};
    wr_en = we; wr_addr = wa; wr_data = wd;
    iss_en = ie; iss_addr = ia;
    n_regs = m_regs;
    n_busy = m_busy;
    if (we && wa != 0 && int'(wa) < NR) begin
      n_regs[wa] = wd;
      n_busy[wa] = 1'b0;
    end
    if (ie && ia != 0 && int'(ia) < NR) n_busy[ia] = 1'b1;
    for (int p = 0; p < NP; p++) begin
      if (re[p]) begin
        a = (p == 0) ? int'(ra0) : int'(ra1);
        if (a == 0 || a >= NR) begin
          e_rd[p] = '0;
          e_rb[p] = 1'b0;
        end else begin
`ifdef REG_FILE_BYPASS_EN
          e_rd[p] = n_regs[a];
          e_rb[p] = n_busy[a];
`else
          e_rd[p] = m_regs[a];
          e_rb[p] = m_busy[a];
`endif
        end
      end
    end
    m_regs = n_regs;
    m_busy = n_busy;
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  initial begin
    model_reset();
    #2 reset_n = 1'b0;
    #1;
    chk("por rd_data", 64'(rd_data), 64'd0);
    chk("por rd_busy", 64'(rd_busy), 64'd0);
    chk("por busy_cnt", 64'(busy_cnt), 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // mid-cycle asynchronous reset
    step("rst_wr", 2'b00, 5'd0, 5'd0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 5'd6);
    step("rst_rd", 2'b11, 5'd5, 5'd6, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    chk("rst pre data", 64'(rd_data[31:0]), 64'hDEADBEEF);
    chk("rst pre busy", 64'(rd_busy), 64'b10);
    #3 reset_n = 1'b0;
    #1;
    model_reset();
    chk("rst async rd_data", 64'(rd_data), 64'd0);
    chk("rst async rd_busy", 64'(rd_busy), 64'd0);
    chk("rst async busy_cnt", 64'(busy_cnt), 64'd0);
    #1 reset_n = 1'b1;
    step("rst_post", 2'b01, 5'd5, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    chk("rst x5 cleared", 64'(rd_data[31:0]), 64'h0);

    // x0 hardwired
    step("x0_wr", 2'b00, 5'd0, 5'd0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0);
    step("x0_rd", 2'b11, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    chk("x0 data", 64'(rd_data), 64'd0);
    chk("x0 busy_cnt", 64'(busy_cnt), 64'd0);

    // read latency, both ports
    step("lat_w3", 2'b00, 5'd0, 5'd0, 1'b1, 5'd3, 32'h11, 1'b0, 5'd0);
    step("lat_w4", 2'b00, 5'd0, 5'd0, 1'b1, 5'd4, 32'h22, 1'b0, 5'd0);
    step("lat_rd", 2'b11, 5'd3, 5'd4, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    chk("lat port0", 64'(rd_data[31:0]), 64'h11);
    chk("lat port1", 64'(rd_data[63:32]), 64'h22);
    chk("lat busy", 64'(rd_busy), 64'd0);
    step("hold", 2'b00, 5'd9, 5'd9, 1'b1, 5'd3, 32'h99, 1'b0, 5'd0);
    chk("hold port0", 64'(rd_data[31:0]), 64'h11);

    // same-edge collision
    step("coll", 2'b01, 5'd7, 5'd0, 1'b1, 5'd7, 32'hA5A5A5A5, 1'b0, 5'd0);
`ifdef REG_FILE_BYPASS_EN
    chk("coll data", 64'(rd_data[31:0]), 64'hA5A5A5A5);
`else
    chk("coll data", 64'(rd_data[31:0]), 64'h0);
`endif

    // scoreboard
    step("sb_i9", 2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9);
    step("sb_i10", 2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd10);
    chk("sb cnt2", 64'(busy_cnt), 64'd2);
    step("sb_rd9", 2'b01, 5'd9, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    chk("sb busy9", 64'(rd_busy[0]), 64'd1);
    step("sb_wi9", 2'b00, 5'd0, 5'd0, 1'b1, 5'd9, 32'h1234, 1'b1, 5'd9);
    chk("sb same cnt", 64'(busy_cnt), 64'd2);
    step("sb_rd9b", 2'b01, 5'd9, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    chk("sb busy9 kept", 64'(rd_busy[0]), 64'd1);
    chk("sb data9", 64'(rd_data[31:0]), 64'h1234);
    step("sb_w9", 2'b00, 5'd0, 5'd0, 1'b1, 5'd9, 32'h1, 1'b0, 5'd0);
    step("sb_w10", 2'b00, 5'd0, 5'd0, 1'b1, 5'd10, 32'h2, 1'b0, 5'd0);
    chk("sb cnt0", 64'(busy_cnt), 64'd0);

    // out-of-range address (NUM_REG=24)
    step("oor_w", 2'b10, 5'd0, 5'd30, 1'b1, 5'd30, 32'h55, 1'b1, 5'd30);
    step("oor_r", 2'b11, 5'd30, 5'd30, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    chk("oor data", 64'(rd_data), 64'd0);
    chk("oor busy", 64'(rd_busy), 64'd0);
    chk("oor cnt", 64'(busy_cnt), 64'd0);

    // randomized traffic, addresses skewed toward a small window for collisions
    for (int i = 0; i < 600; i++) begin
      logic [AW-1:0] ra0, ra1, wa, ia;
      ra0 = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 7));
      ra1 = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 7));
      wa  = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 7));
      ia  = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 7));
      step("rand", NP'($urandom_range(0, 3)), ra0, ra1, 1'($urandom_range(0, 1)), wa,
           $urandom, 1'($urandom_range(0, 1)), ia);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
